// File: rtl/sm_muldiv_if.sv
// sm_muldiv_if: issue/result bundle between the control unit and
// the multiply/divide unit.
interface sm_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       oper;
    logic [WIDTH-1:0] srcA;
    logic [WIDTH-1:0] srcB;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, oper, srcA, srcB,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, oper, srcA, srcB,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/sm_muldiv.sv
// sm_muldiv: iterative MIPS multiply/divide unit owning HI/LO.
// Shift-add multiply, restoring divide, one bit per clock.
module sm_muldiv #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic       clk,
    input  logic       rst,
    sm_muldiv_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opnd;
    logic [WIDTH-1:0]   r_raw_a;
    logic               r_is_div;
    logic               r_div0;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;

    logic               w_idle;
    logic               w_issue;
    logic               w_mt;
    logic               w_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_msum;
    logic [2*WIDTH-1:0] w_mstep;
    logic [WIDTH:0]     w_dtrial;
    logic [2*WIDTH-1:0] w_dstep;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_fix_hi;
    logic [WIDTH-1:0]   w_fix_lo;

    assign w_idle  = (r_state == S_IDLE);
    assign w_issue = bus.start && w_idle && !bus.oper[2];
    assign w_mt    = bus.start && w_idle && (bus.oper[2:1] == 2'b10);

    // Operand magnitudes; only MULT/DIV treat operands as signed
    assign w_signed = !bus.oper[0];
    assign w_a_neg  = w_signed && bus.srcA[WIDTH-1];
    assign w_b_neg  = w_signed && bus.srcB[WIDTH-1];
    assign w_a_mag  = w_a_neg ? -bus.srcA : bus.srcA;
    assign w_b_mag  = w_b_neg ? -bus.srcB : bus.srcB;

    // Multiply step: add multiplicand to upper half if LSB set, shift right
    assign w_msum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opnd};
    assign w_mstep = r_acc[0] ? {w_msum, r_acc[WIDTH-1:1]}
                              : {1'b0, r_acc[2*WIDTH-1:1]};

    // Divide step: {rem, quo} shifts left, trial-subtract divisor from rem
    assign w_dtrial = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]}
                    - {1'b0, r_opnd};
    assign w_dstep  = w_dtrial[WIDTH]
                    ? {r_acc[2*WIDTH-2:0], 1'b0}
                    : {w_dtrial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

    // Sign correction and divide-by-zero override applied in FIX
    assign w_prod = r_neg_q ? -r_acc : r_acc;
    assign w_quo  = r_acc[WIDTH-1:0];
    assign w_rem  = r_acc[2*WIDTH-1:WIDTH];

    // Select the HI/LO values written at the FIX edge
    always_comb begin
        w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
        w_fix_lo = w_prod[WIDTH-1:0];
        if (r_is_div) begin
            if (r_div0) begin
                w_fix_hi = r_raw_a;
                w_fix_lo = '1;
            end else begin
                w_fix_hi = r_neg_r ? -w_rem : w_rem;
                w_fix_lo = r_neg_q ? -w_quo : w_quo;
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_issue) w_next = S_CALC;
            S_CALC:  if (r_cnt == CNT_W'(1)) w_next = S_FIX;
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Datapath: operand latch, iteration, HI/LO write-back
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opnd   <= '0;
            r_raw_a  <= '0;
            r_is_div <= 1'b0;
            r_div0   <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_issue) begin
                        r_cnt    <= CNT_W'(WIDTH);
                        r_is_div <= bus.oper[1];
                        r_div0   <= bus.oper[1] && (bus.srcB == '0);
                        r_raw_a  <= bus.srcA;
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                        if (bus.oper[1]) begin
                            r_opnd <= w_b_mag;
                            r_acc  <= {{WIDTH{1'b0}}, w_a_mag};
                        end else begin
                            r_opnd <= w_a_mag;
                            r_acc  <= {{WIDTH{1'b0}}, w_b_mag};
                        end
                    end else if (w_mt) begin
                        if (bus.oper[0]) r_lo <= bus.srcA;
                        else             r_hi <= bus.srcA;
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    r_acc <= r_is_div ? w_dstep : w_mstep;
                end
                S_FIX: begin
                    r_hi   <= w_fix_hi;
                    r_lo   <= w_fix_lo;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = !w_idle;
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
endmodule

// File: tb/tb_sm_muldiv.sv
// tb_sm_muldiv: randomized scoreboard bench for sm_muldiv.
// Driver queues expected HI/LO; a monitor checks them on each done.
module tb_sm_muldiv;
    localparam int W = 32;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    exp_t sb[$];
    exp_t mon_e;

    sm_muldiv_if #(.WIDTH(W)) bus ();

    sm_muldiv #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Reference: architectural results from plain integer arithmetic
    function automatic void ref_op(input logic [2:0] op,
                                   input logic [W-1:0] a,
                                   input logic [W-1:0] b,
                                   output logic [W-1:0] h,
                                   output logic [W-1:0] l);
        longint sa, sb_, ua, ub, q, r;
        logic [63:0] p, tq, tr;
        sa  = longint'($signed(a));
        sb_ = longint'($signed(b));
        ua  = longint'({32'd0, a});
        ub  = longint'({32'd0, b});
        p = '0;
        tq = '0;
        tr = '0;
        case (op)
            3'd0: p = 64'(sa * sb_);
            3'd1: p = 64'(ua * ub);
            3'd2: begin
                if (b == '0) begin
                    tq = '1;
                    tr = 64'(ua);
                end else if (a == 32'h8000_0000 && b == '1) begin
                    tq = 64'h8000_0000;
                    tr = '0;
                end else begin
                    q = sa / sb_;
                    r = sa % sb_;
                    tq = 64'(q);
                    tr = 64'(r);
                end
                p = {tr[31:0], tq[31:0]};
            end
            default: begin
                if (b == '0) begin
                    tq = '1;
                    tr = 64'(ua);
                end else begin
                    q = ua / ub;
                    r = ua % ub;
                    tq = 64'(q);
                    tr = 64'(r);
                end
                p = {tr[31:0], tq[31:0]};
            end
        endcase
        h = p[63:32];
        l = p[31:0];
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return W'($urandom_range(0, 9));
            default: return W'($urandom);
        endcase
    endfunction

    // Monitor: every done pulse must match the oldest queued result
    always @(negedge clk) begin
        if (bus.done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("res_hi", 64'(bus.hi), 64'(mon_e.hi));
                chk("res_lo", 64'(bus.lo), 64'(mon_e.lo));
                chk("latency", 64'(cyc - mon_e.cyc), 64'(W + 1));
            end
        end
    end

    // Issue one request at the current negedge; returns on a negedge.
    // poke>0 pulses a stray DIVU while busy at that cycle offset.
    task automatic do_op(input logic [2:0] op,
                         input logic [W-1:0] a,
                         input logic [W-1:0] b,
                         input int poke);
        logic [W-1:0] eh, el, ph, pl;
        bit got, hold_ok;
        ph = m_hi;
        pl = m_lo;
        got = 0;
        hold_ok = 1;
        bus.start = 1'b1;
        bus.oper  = op;
        bus.srcA  = a;
        bus.srcB  = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        if (!op[2]) begin
            ref_op(op, a, b, eh, el);
            sb.push_back('{hi: eh, lo: el, cyc: cyc});
            m_hi = eh;
            m_lo = el;
            chk("busy_issue", 64'(bus.busy), 64'd1);
            for (int k = 1; k <= W + 10; k++) begin
                @(negedge clk);
                bus.start = 1'b0;
                if (bus.done) begin
                    got = 1;
                    break;
                end
                if (bus.hi !== ph || bus.lo !== pl || !bus.busy)
                    hold_ok = 0;
                if (k == poke) begin
                    bus.start = 1'b1;
                    bus.oper  = 3'b011;
                    bus.srcA  = 32'd100;
                    bus.srcB  = 32'd3;
                end
            end
            bus.start = 1'b0;
            chk("done_seen", 64'(got), 64'd1);
            chk("hold_busy", 64'(hold_ok), 64'd1);
            chk("busy_at_done", 64'(bus.busy), 64'd0);
        end else begin
            if (!op[1]) begin
                if (op[0]) m_lo = a;
                else       m_hi = a;
            end
            @(negedge clk);
            chk("imm_busy", 64'(bus.busy), 64'd0);
            chk("imm_hi", 64'(bus.hi), 64'(m_hi));
            chk("imm_lo", 64'(bus.lo), 64'(m_lo));
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.oper  = 3'd0;
        bus.srcA  = '0;
        bus.srcB  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_hi", 64'(bus.hi), 64'd0);
        chk("rst_lo", 64'(bus.lo), 64'd0);
        rst = 1'b0;

        do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        chk("t1_hi", 64'(bus.hi), 64'hFFFF_FFFE);
        chk("t1_lo", 64'(bus.lo), 64'h0000_0001);
        do_op(3'd0, 32'hFFFF_FFFD, 32'd7, 0);
        chk("t1b_lo", 64'(bus.lo), 64'hFFFF_FFEB);

        do_op(3'd2, 32'hFFFF_FFF9, 32'd2, 0);
        do_op(3'd3, 32'd7, 32'd2, 0);
        do_op(3'd3, 32'hFFFF_FFFF, 32'd1, 0);

        do_op(3'd2, 32'd5, 32'd0, 0);
        chk("t3_hi", 64'(bus.hi), 64'd5);
        do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        chk("t3b_lo", 64'(bus.lo), 64'h8000_0000);

        do_op(3'd4, 32'h1234, 32'd0, 0);
        do_op(3'd5, 32'h5678, 32'd0, 0);
        do_op(3'd1, 32'd2, 32'd3, 0);
        chk("t4_lo", 64'(bus.lo), 64'd6);

        do_op(3'd1, 32'd6, 32'd7, 10);
        chk("t5_lo", 64'(bus.lo), 64'd42);
        do_op(3'd0, 32'd123, 32'hFFFF_FFF7, W + 1);

        do_op(3'd6, 32'hDEAD, 32'd1, 0);
        do_op(3'd7, 32'hBEEF, 32'd2, 0);

        bus.start = 1'b1;
        bus.oper  = 3'd0;
        bus.srcA  = 32'hFFFF_FFFD;
        bus.srcB  = 32'd5;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (13) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_hi = '0;
        m_lo = '0;
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_hi", 64'(bus.hi), 64'd0);
        chk("abort_lo", 64'(bus.lo), 64'd0);
        repeat (W + 8) @(negedge clk);
        do_op(3'd1, 32'd4, 32'd4, 0);
        chk("t6_lo", 64'(bus.lo), 64'd16);

        for (int n = 0; n < 80; n++) begin
            logic [2:0] op;
            logic [W-1:0] a, b;
            int pk;
            op = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            pk = ($urandom_range(0, 3) == 0) ? $urandom_range(1, W + 1) : 0;
            do_op(op, a, b, pk);
        end

        repeat (W + 5) @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sm_muldiv.md
Name: sm_muldiv

Overview:
- Iterative MIPS multiply/divide unit owning the HI/LO register pair.
- Executes MULT, MULTU, DIV and DIVU over a parametrised operand width, plus MTHI/MTLO writes.
- Sits beside the CPU's ALU: the control unit issues an operation with a start pulse, stalls on busy, and reads hi/lo for MFHI/MFLO.
- Adds multi-cycle sequencing, signed/unsigned modes and architectural HI/LO state, none of which a purely combinational ALU has.

Parameters:
- WIDTH, 32, operand and HI/LO width in bits (minimum 2).
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, do not override.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  issue request, sampled on the rising edge.
- oper  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op.
- srcA  in  WIDTH  multiplicand / dividend; data for MTHI/MTLO.
- srcB  in  WIDTH  multiplier / divisor.
- busy  out  1  operation in progress; new starts are ignored while high.
- done  out  1  one-cycle pulse when HI/LO hold a new mul/div result.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset: state IDLE; busy=0, done=0, hi=0, lo=0; counter and working registers cleared.
- Reset mid-operation aborts it: HI/LO go to 0 and no done pulse is produced.
- States: IDLE, CALC, FIX.
- IDLE, on start=1 with a mul/div oper at edge T:
  - latch operand magnitudes (two's-complement negate of negative operands for MULT/DIV only), result signs and op type;
  - counter=WIDTH; go to CALC; busy=1 from after edge T.
- CALC: one iteration per edge, counter decrements; after WIDTH iterations (edges T+1..T+WIDTH) go to FIX.
  - Multiply: shift-add, 2*WIDTH-bit product.
  - Divide: restoring, one quotient bit per edge.
- FIX (edge T+WIDTH+1): apply sign correction, write HI/LO, go to IDLE.
  - busy=0 and done=1 in the following cycle only.
  - Total start-to-done latency: WIDTH+2 cycles.
- MULT/MULTU: {hi,lo} = full 2*WIDTH-bit product, signed or unsigned.
- DIV/DIVU: lo = quotient truncated toward zero; hi = remainder with the dividend's sign.
- Divide by zero: hi=srcA, lo=all ones, for both signed and unsigned.
  - Still takes the full WIDTH+2 latency with a done pulse.
- Signed overflow (most-negative / -1): lo = most-negative, hi = 0.
- MTHI/MTLO with start=1 in IDLE: hi (or lo) = srcA at edge T, visible the next cycle.
  - busy stays 0; no done pulse; the other register is unchanged.
- Ignored requests, no state change:
  - start=1 while busy=1 (including during FIX);
  - start=1 with oper 11x.
- start in the same cycle done is high is accepted normally (back-to-back issue).
- hi/lo hold their previous values throughout CALC and change only at the FIX edge.
- Counter width CNT_W must not wrap for any legal WIDTH.

Test Plan (WIDTH=32):
1. MULTU srcA=srcB=0xFFFFFFFF -> busy for 33 cycles, done pulse 34 cycles after start, hi=0xFFFFFFFE, lo=0x00000001. MULT -3 x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
2. DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 -> lo=3, hi=1. DIVU 0xFFFFFFFF/1 -> lo=0xFFFFFFFF, hi=0.
3. DIV 5/0 -> hi=5, lo=0xFFFFFFFF, done at 34 cycles. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
4. MTHI 0x1234 then MTLO 0x5678 on consecutive cycles -> hi=0x1234, lo=0x5678, busy never high, no done pulse. Then MULTU 2x3 issued in the cycle after its predecessor's done -> accepted, hi=0, lo=6.
5. Start MULTU 6x7, pulse start with DIVU 100/3 at cycle 10 -> second request ignored; result hi=0, lo=42, exactly one done pulse.
6. Start MULT, assert rst at cycle 15 -> next cycle busy=0, hi=lo=0, no done pulse ever; a fresh MULTU 4x4 afterwards -> lo=16.
